inst_reg_q: RTL and testbench
=============================

Name: inst_reg_q

Overview:
- Parametrised instruction register with a DEPTH-entry prefetch queue, sitting between instruction memory fetch and the control unit.
- Accepts raw instruction words on a valid/ready handshake, buffers them in order, and presents the head entry split into addressing-mode, opcode and address fields.
- Adds flush on branch/jump and occupancy reporting.

Parameters:
- OPCODE_W, 5, opcode field width.
- ADDR_W, 10, address/operand field width.
- DEPTH, 4, queue entries; power of two, >= 2.
- INST_W, 1+OPCODE_W+ADDR_W (16 by default), derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all queued entries (synchronous)
- in_valid  input  1  ins carries a fetched word
- in_ready  output  1  queue can accept a word this cycle
- ins  input  INST_W  raw instruction {addr_mode, opcode, address}
- out_valid  output  1  head entry present
- out_ready  input  1  consumer takes head entry this cycle
- addr_mode  output  1  head ins[INST_W-1]
- opcode  output  OPCODE_W  head ins[INST_W-2 -: OPCODE_W]
- address  output  ADDR_W  head ins[ADDR_W-1:0]
- count  output  $clog2(DEPTH+1)  entries held

Behaviour:
- One clock, clk. rst is asynchronous, active-high.
- Reset state:
  - count=0, out_valid=0, addr_mode/opcode/address=0.
  - Read and write pointers = 0.
  - Storage contents are don't-care.
  - While rst is high, no push or pop takes effect.
- Push and pop conditions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count < DEPTH).
  - Derived from registered state only; no combinational path from out_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0), registered-state derived.
- Field outputs:
  - When out_valid=1, fields decode the head entry.
  - When out_valid=0, fields are forced to 0.
- Latency:
  - A word pushed at edge N appears on the fields after edge N if the queue was empty (one-cycle fill latency).
  - Otherwise it appears after all older entries have been popped.
- Count update:
  - push & pop: count unchanged; both pointers advance.
  - push only: count+1.
  - pop only: count-1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Field split is a fixed bit slice of the stored word:
  - addr_mode = MSB.
  - opcode = next OPCODE_W bits.
  - address = low ADDR_W bits.
  - No sign extension and no other decode.
- flush:
  - At the next edge, pointers and count go to 0; any push or pop in that cycle is ignored.
  - Fields read 0 the following cycle.
  - flush has priority over push/pop.
- Reset mid-operation clears everything asynchronously. The first push after release behaves as from an empty queue.
- Ordering is strict FIFO. No entry is ever duplicated or dropped except by flush or reset.

Decomposition:
- Shared package inst_pkg holds:
  - OPCODE_W, ADDR_W and the derived INST_W.
  - Field slice localparams (ADDR_MODE_BIT, OPCODE_LSB).
  - Packed struct inst_t {addr_mode, opcode, address}, reused by the control unit.
- Sub-module inst_fifo (DEPTH x INST_W storage, pointers, count, flush, in_ready/out_valid).
- Top inst_reg_q instantiates inst_fifo and performs the field split and empty-zero masking.

Test Plan:
- Reset, then push ins=16'hA5C3 -> next cycle: out_valid=1, addr_mode=1, opcode=5'h09, address=10'h1C3, count=1.
- DEPTH=4, out_ready=0, push 0x0001..0x0005 on consecutive cycles -> count reaches 4, in_ready=0, fifth word not accepted; pops then return 0x0001..0x0004 in order.
- count=2 with in_valid=1 and out_ready=1 for 10 cycles (crosses pointer wrap) -> count stays 2; outputs follow the sequence with no gaps or repeats.
- Full queue, out_ready=1, in_valid=1 -> pop occurs, push refused that cycle; count goes 4->3, then the push succeeds next cycle.
- count=3, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, all fields 0; the concurrent word is not stored.
- Assert rst asynchronously mid-burst (count=2) -> outputs zero immediately without a clock edge; after release, push 0x8000 -> addr_mode=1, opcode=0, address=0.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared instruction-format definitions for the fetch/decode path.
package inst_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned INST_W   = 1 + OPCODE_W + ADDR_W;

  // Bit positions of the fields inside a raw instruction word
  localparam int unsigned ADDR_MODE_BIT = INST_W - 1;
  localparam int unsigned OPCODE_LSB    = ADDR_W;

  // Decoded view of an instruction word; the layout matches the raw bit order
  typedef struct packed {
    logic                addr_mode;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   address;
  } inst_t;

endpackage

// File: rtl/inst_fifo.sv
// In-order prefetch queue: DEPTH x WIDTH storage with wrap-around pointers,
// occupancy count and a synchronous flush that overrides push/pop.
module inst_fifo
  import inst_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = INST_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, wr_en;

  // Handshake readiness comes from registered occupancy only, so a full
  // queue refuses a push even when a pop happens in the same cycle.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next-state for pointers and occupancy; flush wins over push/pop
  always_comb begin
    push     = in_valid & in_ready;
    pop      = out_valid & out_ready;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        wr_en    = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/inst_reg_q.sv
// Instruction register with prefetch queue: buffers fetched words in order
// and presents the head entry split into addr_mode / opcode / address.
module inst_reg_q #(
  parameter  int unsigned OPCODE_W = inst_pkg::OPCODE_W,
  parameter  int unsigned ADDR_W   = inst_pkg::ADDR_W,
  parameter  int unsigned DEPTH    = 4,
  localparam int unsigned INST_W   = 1 + OPCODE_W + ADDR_W,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   ins,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                addr_mode,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   address,
  output logic [CNT_W-1:0]    count
);

  localparam int unsigned ADDR_MODE_BIT = INST_W - 1;
  localparam int unsigned OPCODE_LSB    = ADDR_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("inst_reg_q: DEPTH must be a power of two and at least 2");
  end

  logic [INST_W-1:0] head_raw;
  logic [INST_W-1:0] head;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_data   (ins),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_data   (head_raw),
    .count     (count)
  );

  // Mask stale storage so the fields read zero whenever the queue is empty
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = head_raw;
    end
  end

  assign addr_mode = head[ADDR_MODE_BIT];
  assign opcode    = head[OPCODE_LSB +: OPCODE_W];
  assign address   = head[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_reg_q.sv
// Bench for inst_reg_q: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_inst_reg_q;
  import inst_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [INST_W-1:0]   ins = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                addr_mode;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   address;
  logic [CNT_W-1:0]    count;

  int vectors = 0;
  int errors  = 0;

  logic [INST_W-1:0] model_q[$];

  inst_reg_q #(
    .OPCODE_W (OPCODE_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ins       (ins),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .addr_mode (addr_mode),
    .opcode    (opcode),
    .address   (address),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of words, updated on the same edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (model_q.size() < DEPTH);
      do_pop  = out_ready && (model_q.size() != 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(ins);
      end
    end
  end

  // Compare every DUT output against the model midway through each cycle
  always @(negedge clk) begin
    inst_t h;
    h = '0;
    if (model_q.size() != 0) h = inst_t'(model_q[0]);
    check("m_count",     32'(count),     32'(model_q.size()));
    check("m_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check("m_in_ready",  32'(in_ready),  32'(model_q.size() < DEPTH));
    check("m_addr_mode", 32'(addr_mode), 32'(h.addr_mode));
    check("m_opcode",    32'(opcode),    32'(h.opcode));
    check("m_address",   32'(address),   32'(h.address));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_words(input int unsigned base, input int unsigned n);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      ins = INST_W'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < DEPTH + 1; i++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr",  32'(address), 32'd0);
    #9 rst = 1'b0;
    tick();

    // Single push, field split of 16'hA5C3
    in_valid = 1'b1;
    ins      = 16'hA5C3;
    tick();
    in_valid = 1'b0;
    check("t1_valid",     32'(out_valid), 32'd1);
    check("t1_addr_mode", 32'(addr_mode), 32'd1);
    check("t1_opcode",    32'(opcode),    32'h09);
    check("t1_address",   32'(address),   32'h1C3);
    check("t1_count",     32'(count),     32'd1);
    drain();

    // Fill beyond capacity, then pop in order
    push_words(32'h1, 4);
    check("t2_count4",  32'(count), 32'd4);
    check("t2_notready", 32'(in_ready), 32'd0);
    push_words(32'h5, 1);
    check("t2_refused", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int unsigned k = 1; k <= 4; k++) begin
      check("t2_order", 32'(address), 32'(k));
      tick();
    end
    out_ready = 1'b0;
    check("t2_empty", 32'(count), 32'd0);

    // Steady-state push+pop at count=2 across pointer wrap
    push_words(32'h10, 2);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      ins = INST_W'(32'h12 + i);
      check("t3_seq", 32'(address), 32'h10 + i);
      tick();
      check("t3_count", 32'(count), 32'd2);
    end
    drain();

    // Full queue: pop happens, simultaneous push refused
    push_words(32'h20, 4);
    in_valid  = 1'b1;
    ins       = 16'h0024;
    out_ready = 1'b1;
    tick();
    check("t4_count3", 32'(count), 32'd3);
    check("t4_ready",  32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("t4_count4", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      check("t4_order", 32'(address), 32'h21 + k);
      tick();
    end
    out_ready = 1'b0;

    // Flush with concurrent push and pop
    push_words(32'h30, 3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    ins       = 16'h803F;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t5_count",  32'(count), 32'd0);
    check("t5_valid",  32'(out_valid), 32'd0);
    check("t5_mode",   32'(addr_mode), 32'd0);
    check("t5_opcode", 32'(opcode), 32'd0);
    check("t5_addr",   32'(address), 32'd0);
    tick();
    check("t5_stay", 32'(count), 32'd0);

    // Asynchronous reset mid-burst
    push_words(32'h40, 2);
    check("t6_pre", 32'(count), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("t6_count", 32'(count), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_addr",  32'(address), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    in_valid = 1'b1;
    ins      = 16'h8000;
    tick();
    in_valid = 1'b0;
    check("t6_mode",   32'(addr_mode), 32'd1);
    check("t6_opcode", 32'(opcode), 32'd0);
    check("t6_address", 32'(address), 32'd0);
    check("t6_count1", 32'(count), 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
